// File: rtl/uart_wb_scheduler.sv
// rtl/uart_wb_scheduler.sv - Wishbone master that schedules UART TX writes and RX reads
//
// Purpose:
//   Buffers host TX bytes in a FIFO and drives a Wishbone-attached UART.
//   Each service round first reads the UART status register. The status value
//   then decides whether to write the FIFO head to the data register, read a
//   received byte into a single holding slot, or do nothing. When both
//   directions are ready the scheduler alternates between them. After every
//   data write it waits HOLDOFF idle cycles so the UART busy bit can settle.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   tx_data_i, tx_valid_i         host byte push
//   tx_ready_o, tx_level_o        FIFO not-full flag, FIFO occupancy
//   rx_data_o, rx_valid_o         received-byte holding slot
//   rx_ready_i                    host consumes the holding slot
//   rx_en_i                       enables RX polling
//   wbm_adr_o .. wbm_cyc_o        Wishbone master request outputs
//   wbm_dat_i, wbm_ack_i          Wishbone master response inputs

module uart_wb_scheduler #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE  = ADDR_WIDTH'(32'h1000_0000),
  parameter int                    TX_DEPTH   = 16,
  parameter int                    HOLDOFF    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [$clog2(TX_DEPTH):0] tx_level_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  input  logic                      rx_en_i,
  output logic [ADDR_WIDTH-1:0]     wbm_adr_o,
  output logic [DATA_WIDTH-1:0]     wbm_dat_o,
  output logic                      wbm_we_o,
  output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_cyc_o,
  input  logic [DATA_WIDTH-1:0]     wbm_dat_i,
  input  logic                      wbm_ack_i
);

  localparam int PTR_W  = $clog2(TX_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  localparam logic [ADDR_WIDTH-1:0] ADR_DATA = UART_BASE;
  localparam logic [ADDR_WIDTH-1:0] ADR_STAT = UART_BASE + ADDR_WIDTH'(5);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RD_STAT = 3'd2,
    DECIDE  = 3'd3,
    WR_DATA = 3'd4,
    RD_DATA = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               run_q, run_d;
  logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         status_q, status_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               last_rx_q, last_rx_d;
  logic               served_q, served_d;
  logic [HCNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]         mem_q [TX_DEPTH];

  logic [LVL_W-1:0]   level;
  logic               push;
  logic               pop;
  logic               tx_ok;
  logic               rx_ok;
  logic [7:0]         head;

  // Only the low status/data byte is meaningful to this block.
  logic unused_bits;
  assign unused_bits = ^{wbm_dat_i, status_q};

  // The extra wrap bit makes full (difference TX_DEPTH) distinct from empty.
  assign level      = wr_ptr_q - rd_ptr_q;
  assign tx_ready_o = (level != LVL_W'(TX_DEPTH));
  assign tx_level_o = level;
  assign push       = tx_valid_i && tx_ready_o;
  assign pop        = (state_q == WR_DATA) && wbm_ack_i;
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign tx_ok      = status_q[5] && (level != '0);
  assign rx_ok      = status_q[0] && rx_en_i && !rx_valid_q;

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // run_q holds the FSM for one edge after reset release.
        if (run_q && ((level != '0) || (rx_en_i && !rx_valid_q))) begin
          state_d = RD_STAT;
        end
      end
      RD_STAT: begin
        if (wbm_ack_i) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        // On a tie, serve RX only when TX went last; until the first data
        // transfer after reset (served_q low) TX wins.
        if (tx_ok && rx_ok) begin
          state_d = (served_q && !last_rx_q) ? RD_DATA : WR_DATA;
        end else if (tx_ok) begin
          state_d = WR_DATA;
        end else if (rx_ok) begin
          state_d = RD_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (wbm_ack_i) begin
          state_d = (HOLDOFF > 0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      RD_DATA: begin
        if (wbm_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from state; every field is zero while stb is low.
  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = '0;
    wbm_stb_o = 1'b0;
    wbm_cyc_o = 1'b0;
    case (state_q)
      RD_STAT: begin
        wbm_adr_o = ADR_STAT;
        wbm_sel_o = SEL_W'(1);
        wbm_stb_o = 1'b1;
        wbm_cyc_o = 1'b1;
      end
      WR_DATA: begin
        wbm_adr_o = ADR_DATA;
        wbm_dat_o = DATA_WIDTH'(head);
        wbm_we_o  = 1'b1;
        wbm_sel_o = SEL_W'(1);
        wbm_stb_o = 1'b1;
        wbm_cyc_o = 1'b1;
      end
      RD_DATA: begin
        wbm_adr_o = ADR_DATA;
        wbm_sel_o = SEL_W'(1);
        wbm_stb_o = 1'b1;
        wbm_cyc_o = 1'b1;
      end
      default: begin
        wbm_stb_o = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    run_d      = 1'b1;
    wr_ptr_d   = wr_ptr_q + LVL_W'(push);
    rd_ptr_d   = rd_ptr_q + LVL_W'(pop);
    status_d   = status_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    last_rx_d  = last_rx_q;
    served_d   = served_q;
    hold_cnt_d = '0;

    if ((state_q == RD_STAT) && wbm_ack_i) begin
      status_d = wbm_dat_i[7:0];
    end

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    if (pop) begin
      last_rx_d = 1'b0;
      served_d  = 1'b1;
    end

    // RD_DATA is only entered with the slot empty, so this never races the clear.
    if ((state_q == RD_DATA) && wbm_ack_i) begin
      rx_data_d  = wbm_dat_i[7:0];
      rx_valid_d = 1'b1;
      last_rx_d  = 1'b1;
      served_d   = 1'b1;
    end

    if (state_q == HOLD) begin
      hold_cnt_d = hold_cnt_q + HCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      status_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_rx_q  <= 1'b0;
      served_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      run_q      <= run_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      status_q   <= status_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_rx_q  <= last_rx_d;
      served_q   <= served_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= tx_data_i;
    end
  end

endmodule

// File: tb/tb_uart_wb_scheduler.sv
// tb/tb_uart_wb_scheduler.sv - directed self-checking bench for uart_wb_scheduler

module tb_uart_wb_scheduler;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [4:0]  tx_level_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        rx_en_i;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  int n_vec = 0;
  int n_err = 0;

  uart_wb_scheduler dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_level_o (tx_level_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .rx_en_i    (rx_en_i),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
    n_vec++;
    assert (obsv === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obsv, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_stb(input string tag, output int waited);
    waited = 0;
    @(negedge clk_i);
    while (!wbm_stb_o && waited < 60) begin
      waited++;
      @(negedge clk_i);
    end
    chk({tag, ".stb"}, wbm_stb_o, 1);
  endtask

  task automatic bus_txn(input string tag, input logic [31:0] exp_adr, input logic exp_we,
                         input logic [31:0] exp_dat, input logic [31:0] rdata, input int exp_wait);
    int w;
    wait_stb(tag, w);
    if (exp_wait >= 0) chk({tag, ".gap"}, w, exp_wait);
    if (wbm_stb_o) begin
      chk({tag, ".adr"}, wbm_adr_o, exp_adr);
      chk({tag, ".we"}, wbm_we_o, exp_we);
      chk({tag, ".sel"}, wbm_sel_o, 4'b0001);
      chk({tag, ".cyc"}, wbm_cyc_o, 1);
      if (exp_we) chk({tag, ".dat"}, wbm_dat_o, exp_dat);
      wbm_dat_i = rdata;
      wbm_ack_i = 1'b1;
      @(posedge clk_i);
      #1;
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
    end
  endtask

  task automatic quiet(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk_i);
      if (wbm_stb_o || wbm_cyc_o || wbm_we_o || (wbm_dat_o != '0)) bad = 1'b1;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int w;
    rst_i      = 1'b0;
    tx_data_i  = '0;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    rx_en_i    = 1'b0;
    wbm_dat_i  = '0;
    wbm_ack_i  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst.stb", wbm_stb_o, 0);
    chk("rst.cyc", wbm_cyc_o, 0);
    chk("rst.we", wbm_we_o, 0);
    chk("rst.adr", wbm_adr_o, 0);
    chk("rst.dat", wbm_dat_o, 0);
    chk("rst.sel", wbm_sel_o, 0);
    chk("rst.level", tx_level_o, 0);
    chk("rst.ready", tx_ready_o, 1);
    chk("rst.rxv", rx_valid_o, 0);
    chk("rst.rxd", rx_data_o, 0);

    // Release with a byte pushed on the first edge: stb only after the second edge
    rst_i      = 1'b1;
    tx_data_i  = 8'h41;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    chk("rel.edge1.stb", wbm_stb_o, 0);
    chk("rel.edge1.level", tx_level_o, 1);
    @(negedge clk_i);
    chk("rel.edge2.stb", wbm_stb_o, 1);
    bus_txn("a_stat", BASE + 5, 0, 0, 32'h20, 0);
    bus_txn("a_wr", BASE, 1, 32'h41, 0, 1);
    chk("a.level", tx_level_o, 0);
    quiet(8, "a.quiet");

    // Holdoff: exactly two HOLD cycles plus one IDLE before the next status read
    push(8'h11);
    push(8'h22);
    bus_txn("b_stat1", BASE + 5, 0, 0, 32'h20, -1);
    bus_txn("b_wr1", BASE, 1, 32'h11, 0, 1);
    bus_txn("b_stat2", BASE + 5, 0, 0, 32'h20, 3);
    bus_txn("b_wr2", BASE, 1, 32'h22, 0, 1);
    chk("b.level", tx_level_o, 0);

    // Fill to 16 with the UART never ready; the 17th push is dropped
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    chk("c.level16", tx_level_o, 16);
    chk("c.ready", tx_ready_o, 0);
    push(8'hEE);
    chk("c.level17", tx_level_o, 16);
    bus_txn("c_poll0", BASE + 5, 0, 0, 32'h00, 0);
    bus_txn("c_poll1", BASE + 5, 0, 0, 32'h00, 2);
    bus_txn("c_poll2", BASE + 5, 0, 0, 32'h00, 2);
    chk("c.level_kept", tx_level_o, 16);
    for (int i = 0; i < 16; i++) begin
      bus_txn($sformatf("c_st%0d", i), BASE + 5, 0, 0, 32'h20, -1);
      bus_txn($sformatf("c_wr%0d", i), BASE, 1, 32'hA0 + i, 0, 1);
    end
    chk("c.drained", tx_level_o, 0);
    chk("c.ready2", tx_ready_o, 1);

    // Reset during WR_DATA with three bytes queued
    push(8'h31);
    push(8'h32);
    push(8'h33);
    bus_txn("d_stat", BASE + 5, 0, 0, 32'h20, -1);
    wait_stb("d_wr", w);
    chk("d.we", wbm_we_o, 1);
    chk("d.level3", tx_level_o, 3);
    rst_i = 1'b0;
    #1;
    chk("d.stb_async", wbm_stb_o, 0);
    chk("d.cyc_async", wbm_cyc_o, 0);
    chk("d.adr_async", wbm_adr_o, 0);
    chk("d.level_async", tx_level_o, 0);
    @(negedge clk_i);
    rst_i     = 1'b1;
    wbm_ack_i = 1'b1;
    @(negedge clk_i);
    wbm_ack_i = 1'b0;
    chk("d.level_after", tx_level_o, 0);
    quiet(6, "d.quiet");

    // TX first at a tie after reset, then RX read
    rx_en_i = 1'b1;
    push(8'h55);
    bus_txn("e_stat1", BASE + 5, 0, 0, 32'h21, -1);
    bus_txn("e_wr", BASE, 1, 32'h55, 0, 1);
    bus_txn("e_stat2", BASE + 5, 0, 0, 32'h21, 3);
    bus_txn("e_rd", BASE, 0, 0, 32'h7A, 1);
    chk("e.rxv", rx_valid_o, 1);
    chk("e.rxd", rx_data_o, 8'h7A);

    // Slot full: no RD_DATA until the host consumes it
    quiet(4, "f.idle_full");
    push(8'h66);
    bus_txn("f_stat1", BASE + 5, 0, 0, 32'h01, -1);
    bus_txn("f_stat2", BASE + 5, 0, 0, 32'h01, 2);
    wait_stb("f_pend", w);
    rx_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_ready_i = 1'b0;
    chk("f.rxv_clr", rx_valid_o, 0);
    bus_txn("f_stat3", BASE + 5, 0, 0, 32'h01, 0);
    bus_txn("f_rd", BASE, 0, 0, 32'h3C, 1);
    chk("f.rxv", rx_valid_o, 1);
    chk("f.rxd", rx_data_o, 8'h3C);
    chk("f.level", tx_level_o, 1);
    rx_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_ready_i = 1'b0;
    chk("f.rxv_clr2", rx_valid_o, 0);

    // Ack held off five cycles, then a tie after an RX read goes to TX
    wait_stb("g_stat", w);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("g.stb%0d", i), wbm_stb_o, 1);
      chk($sformatf("g.adr%0d", i), wbm_adr_o, BASE + 5);
      chk($sformatf("g.we%0d", i), wbm_we_o, 0);
      chk($sformatf("g.sel%0d", i), wbm_sel_o, 4'b0001);
      @(negedge clk_i);
    end
    wbm_dat_i = 32'h21;
    wbm_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    bus_txn("g_wr", BASE, 1, 32'h66, 0, 1);
    rx_en_i = 1'b0;
    chk("g.level", tx_level_o, 0);
    quiet(8, "g.quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
